// File: rtl/div_if.sv
// Request/result bundle between the execute stage and the multi-cycle divider.
// The master side issues divides and consumes results; the divider is the slave.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor, cancel,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, cancel,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: sign-magnitude operands, one quotient
// bit per cycle, results registered for LO (quotient) and HI (remainder).
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    div_if.slave dif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] qreg_q, qreg_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] abs_dividend, abs_divisor;
    logic [WIDTH:0]   shifted, trial;

    always_comb begin
        abs_dividend = (dif.is_signed && dif.dividend[WIDTH-1]) ? -dif.dividend : dif.dividend;
        abs_divisor  = (dif.is_signed && dif.divisor[WIDTH-1])  ? -dif.divisor  : dif.divisor;
        // Restoring step: the trial difference is one bit wider so its MSB is the borrow.
        shifted      = {prem_q, qreg_q[WIDTH-1]};
        trial        = shifted - {1'b0, dvs_q};
    end

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        prem_d    = prem_q;
        qreg_d    = qreg_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (dif.start && !dif.cancel) begin
                    neg_quo_d = dif.is_signed & (dif.dividend[WIDTH-1] ^ dif.divisor[WIDTH-1]);
                    neg_rem_d = dif.is_signed & dif.dividend[WIDTH-1];
                    cnt_d     = '0;
                    last_d    = 1'b0;
                    prem_d    = '0;
                    qreg_d    = abs_dividend;
                    dvs_d     = abs_divisor;
                    dbz_d     = 1'b0;
                    if (dif.divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dif.dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (dif.cancel) begin
                    state_d = IDLE;
                end else if (last_q) begin
                    // All WIDTH iterations are in; apply the sign fix-up while loading the outputs.
                    quo_d   = neg_quo_q ? -qreg_q : qreg_q;
                    rem_d   = neg_rem_q ? -prem_q : prem_q;
                    state_d = DONE;
                end else begin
                    prem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    qreg_d = {qreg_q[WIDTH-2:0], ~trial[WIDTH]};
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            prem_q    <= '0;
            qreg_q    <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            prem_q    <= prem_d;
            qreg_q    <= qreg_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign dif.busy        = (state_q != IDLE);
    assign dif.done        = (state_q == DONE);
    assign dif.quotient    = quo_q;
    assign dif.remainder   = rem_q;
    assign dif.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic reference model plus a per-cycle
// comparator, driven by directed divides, cancels and an asynchronous reset.
module tb_div_unit;
    localparam int W        = 32;
    localparam int NORM_LAT = W + 2;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    div_if #(.WIDTH(W)) dif ();

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the arithmetic definition of DIV/DIVU.
    function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        res_t res;
        res.dbz = 1'b0;
        if (b == '0) begin
            res.q   = '1;
            res.r   = a;
            res.dbz = 1'b1;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                res.q = a;
                res.r = '0;
            end else begin
                res.q = $signed(a) / $signed(b);
                res.r = $signed(a) % $signed(b);
            end
        end else begin
            res.q = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    // Timing model: busy cycles left, with results committed on entry to the done cycle.
    int           m_left = 0;
    res_t         m_pend;
    logic [W-1:0] exp_q   = '0;
    logic [W-1:0] exp_r   = '0;
    logic         exp_dbz = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        res_t nr;
        if (rst) begin
            m_left  <= 0;
            exp_q   <= '0;
            exp_r   <= '0;
            exp_dbz <= 1'b0;
        end else if (m_left == 0) begin
            if (dif.start && !dif.cancel) begin
                nr = ref_div(dif.dividend, dif.divisor, dif.is_signed);
                m_pend  <= nr;
                exp_dbz <= nr.dbz;
                if (nr.dbz) begin
                    m_left <= 1;
                    exp_q  <= nr.q;
                    exp_r  <= nr.r;
                end else begin
                    m_left <= NORM_LAT;
                end
            end
        end else if (dif.cancel) begin
            m_left <= 0;
        end else begin
            if (m_left == 2) begin
                exp_q <= m_pend.q;
                exp_r <= m_pend.r;
            end
            m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", W'(dif.busy), W'(m_left != 0));
            check("done", W'(dif.done), W'(m_left == 1));
            check("quotient", dif.quotient, exp_q);
            check("remainder", dif.remainder, exp_r);
            check("div_by_zero", W'(dif.div_by_zero), W'(exp_dbz));
        end
    end

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input bit poke, input int exp_cyc,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        int cyc;
        @(negedge clk);
        dif.start     = 1'b1;
        dif.is_signed = s;
        dif.dividend  = a;
        dif.divisor   = b;
        @(negedge clk);
        dif.start = 1'b0;
        cyc = 1;
        while (!dif.done && cyc < 100) begin
            if (poke && cyc == 3) begin
                dif.start    = 1'b1;
                dif.dividend = 32'd5;
                dif.divisor  = 32'd5;
            end
            if (poke && cyc == 6) dif.start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (!dif.done) check({name, "_done_timeout"}, 32'd0, 32'd1);
        check({name, "_latency"}, W'(cyc), W'(exp_cyc));
        check({name, "_q"}, dif.quotient, eq);
        check({name, "_r"}, dif.remainder, er);
        check({name, "_dbz"}, W'(dif.div_by_zero), W'(edbz));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        res_t pin;
        dif.start     = 1'b0;
        dif.is_signed = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        dif.cancel    = 1'b0;

        pin = ref_div(32'd100, 32'd7, 1'b0);
        check("model_u100_7_q", pin.q, 32'h0000_000E);
        pin = ref_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        check("model_sm7_2_r", pin.r, 32'hFFFF_FFFF);
        pin = ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("model_ovf_q", pin.q, 32'h8000_0000);

        #3;
        check("rst_busy", W'(dif.busy), 32'd0);
        check("rst_done", W'(dif.done), 32'd0);
        check("rst_q", dif.quotient, 32'd0);
        check("rst_r", dif.remainder, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        run_op("u100_7",   32'd100,         32'd7,           1'b0, 1'b0, 34, 32'h0000_000E, 32'h0000_0002, 1'b0);
        run_op("sm7_2",    32'hFFFF_FFF9,   32'd2,           1'b1, 1'b0, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("s7_m2",    32'd7,           32'hFFFF_FFFE,   1'b1, 1'b0, 34, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0);
        run_op("s_ovf",    32'h8000_0000,   32'hFFFF_FFFF,   1'b1, 1'b0, 34, 32'h8000_0000, 32'h0000_0000, 1'b0);
        run_op("u_ovf",    32'h8000_0000,   32'hFFFF_FFFF,   1'b0, 1'b0, 34, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("dbz",      32'h1234_5678,   32'd0,           1'b1, 1'b0, 1,  32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run_op("dbz_clr",  32'd100,         32'd7,           1'b0, 1'b0, 34, 32'h0000_000E, 32'h0000_0002, 1'b0);
        run_op("poke",     32'd1000,        32'd3,           1'b0, 1'b1, 34, 32'h0000_014D, 32'h0000_0001, 1'b0);
        run_op("u100_7b",  32'd100,         32'd7,           1'b0, 1'b0, 34, 32'h0000_000E, 32'h0000_0002, 1'b0);

        // Cancel on the 10th RUN cycle: no done, previous results held.
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 32'd1000;
        dif.divisor  = 32'd3;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (9) @(negedge clk);
        dif.cancel = 1'b1;
        @(negedge clk);
        dif.cancel = 1'b0;
        check("cancel_busy", W'(dif.busy), 32'd0);
        check("cancel_done", W'(dif.done), 32'd0);
        repeat (3) @(negedge clk);
        check("cancel_hold_q", dif.quotient, 32'h0000_000E);
        check("cancel_hold_r", dif.remainder, 32'h0000_0002);

        // Start together with cancel in IDLE is dropped.
        dif.start    = 1'b1;
        dif.cancel   = 1'b1;
        dif.dividend = 32'd9;
        dif.divisor  = 32'd3;
        @(negedge clk);
        dif.start  = 1'b0;
        dif.cancel = 1'b0;
        check("start_cancel_busy", W'(dif.busy), 32'd0);

        // Asynchronous reset mid-RUN clears everything without a clock edge.
        dif.start    = 1'b1;
        dif.dividend = 32'd100;
        dif.divisor  = 32'd7;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", W'(dif.busy), 32'd0);
        check("arst_done", W'(dif.done), 32'd0);
        check("arst_q", dif.quotient, 32'd0);
        check("arst_r", dif.remainder, 32'd0);
        check("arst_dbz", W'(dif.div_by_zero), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        run_op("post_rst", 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 1'b0, 34, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 integer divider that executes DIV_CONTROL and DIVU_CONTROL operations for the execute stage.
- It sits beside the single-cycle ALU and consumes the decoded divide control plus both source operands.
- It returns the quotient (destined for LO) and the remainder (destined for HI).
- While it is busy it stalls the pipeline through busy.

Parameters:
WIDTH, 32, operand/result width in bits (must be ≥2).
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request a divide; sampled only in IDLE.
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
dividend  input  WIDTH  rs operand; sampled with start.
divisor  input  WIDTH  rt operand; sampled with start.
cancel  input  1  pipeline flush/exception; aborts the operation in progress.
busy  output  1  high whenever state != IDLE; drives the pipeline stall.
done  output  1  one-cycle pulse: results are valid this cycle.
quotient  output  WIDTH  result for LO; registered.
remainder  output  WIDTH  result for HI; registered.
div_by_zero  output  1  set with done when the divisor was 0.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, all internal registers 0. Reset during RUN or DONE aborts immediately; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and cancel=0 latches the operands. It captures sign_q = is_signed & (dividend[MSB] ^ divisor[MSB]) and sign_r = is_signed & dividend[MSB].
  - Magnitudes are taken as the two's-complement absolute value when is_signed, else the raw value. |−2^(WIDTH−1)| = 2^(WIDTH−1) as unsigned, which needs no extra bit.
  - divisor==0 goes to DONE directly (fast path). Otherwise go to RUN with counter=0, partial remainder=0, and the quotient shift register loaded with |dividend|.
- RUN (one restoring iteration per cycle):
  - Shift {prem, qreg} left by 1, then trial = prem − |divisor| computed at WIDTH+1 bits.
  - If trial is non-negative: prem = trial, qreg[0] = 1. Otherwise qreg[0] = 0.
  - counter increments. After iteration WIDTH (counter == WIDTH−1 at the edge), go to DONE.
- DONE:
  - Lasts one cycle with done=1 and busy=1; next edge goes to IDLE.
  - quotient/remainder are loaded on the edge entering DONE: quotient = sign_q ? −qreg : qreg; remainder = sign_r ? −prem : prem.
- Divide-by-zero fast path: quotient = all ones, remainder = dividend (unmodified), div_by_zero=1. This is identical for signed and unsigned operation.
- div_by_zero is cleared on the next accepted start and is otherwise held.
- Latency: start accepted at edge E0; normal done during the cycle after edge E(WIDTH+1), i.e. busy is high for WIDTH+2 cycles. Divide-by-zero: done in the cycle after E0, busy for 1 cycle.
- Output hold: quotient/remainder hold their values from the last completed operation until the next DONE load. They are never modified mid-run.
- Cancel:
  - cancel=1 in RUN or DONE forces IDLE at the next edge.
  - A cancelled operation never asserts done. If cancel arrives during the DONE cycle, done is still high in that cycle, because the results were already loaded.
  - Output registers are not altered by cancel.
- Simultaneous events:
  - start while busy is ignored; the caller holds the request.
  - start and cancel together in IDLE: cancel wins and the start is dropped.
  - rst overrides everything.
- Overflow: signed −2^(WIDTH−1) / −1 gives quotient = 0x80000000 and remainder = 0, via wrap-around and with no flag.
- Wrap: counter never exceeds WIDTH−1; it resets to 0 on every accepted start.

Test Plan:
- Unsigned 100 / 7: start with is_signed=0 → busy for 34 cycles, done exactly 33 cycles after the start edge. Required: quotient=0x0000000E, remainder=0x00000002, div_by_zero=0.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
- Signed 7 / −2 → quotient=0xFFFFFFFD, remainder=0x00000001.
- Overflow case, 0x80000000 by 0xFFFFFFFF:
  - Signed → quotient=0x80000000, remainder=0.
  - Unsigned → quotient=0, remainder=0x80000000.
- Divide by zero: dividend=0x12345678, divisor=0 → done in the cycle after start. Required: quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. The next normal divide must clear div_by_zero.
- Cancel and reset:
  - Cancel at the 10th RUN cycle → busy=0 after the next edge, no done pulse, outputs keep the previous result.
  - start asserted during RUN is ignored.
  - Asynchronous rst mid-RUN → busy=0 and all outputs 0 immediately, without waiting for a clock edge.
